// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit ALU: latches one op,
// holds the ALU inputs for the op's settling time, and returns the result as a pulse.
module alu_req_arbiter #(
  parameter int ALU_LAT = 1,
  parameter int MOD_LAT = 34
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  output logic        rsp0_lt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  output logic        rsp1_lt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_clear,
  input  logic [31:0] alu_o,
  input  logic        alu_lt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [2:0] OP_MOD  = 3'b111;
  localparam logic [7:0] ALU_CNT = 8'(ALU_LAT);
  localparam logic [7:0] MOD_CNT = 8'(MOD_LAT);

  state_t      state, state_next;
  logic        last_grant;
  logic        gnt_id;
  logic        grant0, grant1, handshake;
  logic [7:0]  cnt;

  // Ties go to the requester that was not granted last; ready is held low during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && reset) begin
      if (req0_valid && (!req1_valid || last_grant)) grant0 = 1'b1;
      else if (req1_valid)                           grant1 = 1'b1;
    end
  end

  assign handshake  = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt == 8'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_clear  = (state == ISSUE);
    busy       = (state != IDLE);
    rsp0_valid = (state == DONE) && !gnt_id;
    rsp1_valid = (state == DONE) &&  gnt_id;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      cnt        <= 8'd0;
    end else begin
      if (handshake) begin
        gnt_id     <= grant1;
        last_grant <= grant1;
      end
      if (state == ISSUE)     cnt <= (alu_op == OP_MOD) ? MOD_CNT : ALU_CNT;
      else if (state == WAIT) cnt <= cnt - 8'd1;
    end
  end

  // ALU operands persist until the next handshake so the ALU sees stable inputs while idle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_op      <= 3'd0;
      rsp0_result <= 32'd0;
      rsp0_lt     <= 1'b0;
      rsp1_result <= 32'd0;
      rsp1_lt     <= 1'b0;
    end else begin
      if (handshake) begin
        alu_op <= grant1 ? req1_op : req0_op;
        alu_a  <= grant1 ? req1_a  : req0_a;
        alu_b  <= grant1 ? req1_b  : req0_b;
      end
      if (state == WAIT && cnt == 8'd1) begin
        if (gnt_id) begin
          rsp1_result <= alu_o;
          rsp1_lt     <= alu_lt;
        end else begin
          rsp0_result <= alu_o;
          rsp0_lt     <= alu_lt;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a cycle-level reference model (grant rules plus latency
// arithmetic), a behavioural ALU with a slow MOD, table vectors, directed and random traffic.
`timescale 1ns/1ps
module tb_alu_req_arbiter;

  localparam int ALU_LAT = 1;
  localparam int MOD_LAT = 34;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_lt;
  logic [2:0]  req0_op;
  logic [31:0] req0_a, req0_b, rsp0_result;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_lt;
  logic [2:0]  req1_op;
  logic [31:0] req1_a, req1_b, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_o;
  logic [2:0]  alu_op;
  logic        alu_clear, alu_lt, busy;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_req_arbiter #(.ALU_LAT(ALU_LAT), .MOD_LAT(MOD_LAT)) dut (
    .CLK(CLK), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_lt(rsp0_lt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_lt(rsp1_lt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_clear(alu_clear),
    .alu_o(alu_o), .alu_lt(alu_lt), .busy(busy)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5:    return a + b;
      3'd6:    return a - b;
      default: return (b == 32'd0) ? a : (a % b);
    endcase
  endfunction

  function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b);
    return $signed(a) < $signed(b);
  endfunction

  function automatic int now_cyc();
    return int'($time / 10);
  endfunction

  // Behavioural ALU: MOD output is garbage until MOD_LAT cycles after the clear strobe.
  int mod_cnt = 1000;
  always @(posedge CLK) begin
    if (alu_clear) mod_cnt <= 0;
    else if (mod_cnt < 1000) mod_cnt <= mod_cnt + 1;
  end
  always_comb begin
    alu_lt = ref_lt(alu_a, alu_b);
    alu_o  = (alu_op == 3'd7 && mod_cnt < MOD_LAT - 1) ? 32'hDEADBEEF : ref_res(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an op handshaken in cycle H occupies cycles H+1..H+LAT+2,
  // clears in H+1 and responds in H+LAT+2.
  bit          mon_en = 1'b0;
  bit          m_active, m_last, m_id;
  int          m_hs, m_lat;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  logic        m_lt;
  logic [31:0] rsp_r [2];
  logic        rsp_l [2];

  always @(negedge CLK) begin
    if (mon_en) begin
      int  c;
      bit  g0, g1, done;
      c = now_cyc();
      if (!reset) begin
        chk("rst_ready0", req0_ready, 0);  chk("rst_ready1", req1_ready, 0);
        chk("rst_busy", busy, 0);          chk("rst_clear", alu_clear, 0);
        chk("rst_rsp0v", rsp0_valid, 0);   chk("rst_rsp1v", rsp1_valid, 0);
        chk("rst_rsp0r", rsp0_result, 0);  chk("rst_rsp1r", rsp1_result, 0);
        chk("rst_lt0", rsp0_lt, 0);        chk("rst_lt1", rsp1_lt, 0);
        chk("rst_alu_a", alu_a, 0);        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        m_active = 1'b0; m_last = 1'b1; m_id = 1'b0;
        m_a = 0; m_b = 0; m_op = 0;
        rsp_r[0] = 0; rsp_r[1] = 0; rsp_l[0] = 0; rsp_l[1] = 0;
      end else begin
        if (m_active && c > m_hs + m_lat + 2) m_active = 1'b0;
        g0   = !m_active && req0_valid && (!req1_valid || m_last);
        g1   = !m_active && req1_valid && (!req0_valid || !m_last);
        done = m_active && (c == m_hs + m_lat + 2);
        if (done) begin
          rsp_r[m_id] = m_res;
          rsp_l[m_id] = m_lt;
        end
        chk("ready0", req0_ready, g0);
        chk("ready1", req1_ready, g1);
        chk("busy", busy, m_active);
        chk("alu_clear", alu_clear, m_active && c == m_hs + 1);
        chk("rsp0_valid", rsp0_valid, done && !m_id);
        chk("rsp1_valid", rsp1_valid, done && m_id);
        chk("rsp0_result", rsp0_result, rsp_r[0]);
        chk("rsp1_result", rsp1_result, rsp_r[1]);
        chk("rsp0_lt", rsp0_lt, rsp_l[0]);
        chk("rsp1_lt", rsp1_lt, rsp_l[1]);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", alu_op, m_op);
        if (g0 || g1) begin
          m_active = 1'b1;
          m_hs     = c;
          m_id     = g1;
          m_last   = g1;
          m_op     = g1 ? req1_op : req0_op;
          m_a      = g1 ? req1_a  : req0_a;
          m_b      = g1 ? req1_b  : req0_b;
          m_lat    = (m_op == 3'd7) ? MOD_LAT : ALU_LAT;
          m_res    = ref_res(m_op, m_a, m_b);
          m_lt     = ref_lt(m_a, m_b);
        end
      end
    end
  end

  task automatic do_op(input int who, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int max_wait, input bit must, input string tag,
                       output bit granted, output logic [31:0] res, output logic lt, output int hs);
    int lat;
    granted = 1'b0; res = 'x; lt = 1'bx; hs = -1; lat = -1;
    @(posedge CLK); #1;
    if (who == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    else          begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    for (int w = 0; w < max_wait; w++) begin
      @(negedge CLK);
      if ((who == 0) ? req0_ready : req1_ready) begin
        granted = 1'b1;
        hs = now_cyc();
        break;
      end
    end
    @(posedge CLK); #1;
    if (who == 0) req0_valid = 0; else req1_valid = 0;
    if (must && !granted) chk({tag, "_grant"}, 0, 1);
    if (granted) begin
      for (int k = 1; k <= 400; k++) begin
        @(negedge CLK);
        if ((who == 0) ? rsp0_valid : rsp1_valid) begin
          lat = k;
          res = (who == 0) ? rsp0_result : rsp1_result;
          lt  = (who == 0) ? rsp0_lt : rsp1_lt;
          break;
        end
      end
      chk({tag, "_lat"}, lat, ((op == 3'd7) ? MOD_LAT : ALU_LAT) + 2);
      chk({tag, "_res"}, res, ref_res(op, a, b));
      chk({tag, "_lt"}, lt, ref_lt(a, b));
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #2 reset = 0;
    @(posedge CLK); @(posedge CLK); #1 reset = 1;
  endtask

  task automatic rand_thread(input int who);
    logic [2:0]  op;
    logic [31:0] a, b, r;
    logic        l;
    bit          g;
    int          h;
    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge CLK);
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) do_op(who, op, a, b, $urandom_range(1, 2), 1'b0, "rnd_tease", g, r, l, h);
      else                           do_op(who, op, a, b, 600, 1'b1, "rnd", g, r, l, h);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        lt;
  } vec_t;
  vec_t vecs [13];

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit          g;
    logic [31:0] r0, r1, ra, rb;
    logic        l0, l1, la, lb;
    int          h0, h1, h0b, h1b, seen;

    vecs[0]  = '{3'd5, 32'd5,         32'd7,         32'd12,        1'b1};
    vecs[1]  = '{3'd7, 32'd17,        32'd5,         32'd2,         1'b0};
    vecs[2]  = '{3'd6, 32'd9,         32'd3,         32'd6,         1'b0};
    vecs[3]  = '{3'd4, 32'd3,         32'd9,         32'd1,         1'b1};
    vecs[4]  = '{3'd2, 32'hFFFF0000,  32'h0F0F0F0F,  32'hF0F00F0F,  1'b1};
    vecs[5]  = '{3'd3, 32'd0,         32'd0,         32'hFFFFFFFF,  1'b0};
    vecs[6]  = '{3'd0, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b1};
    vecs[7]  = '{3'd1, 32'h12340000,  32'h00005678,  32'h12345678,  1'b0};
    vecs[8]  = '{3'd6, 32'd0,         32'd1,         32'hFFFFFFFF,  1'b1};
    vecs[9]  = '{3'd4, 32'h80000000,  32'h7FFFFFFF,  32'd1,         1'b1};
    vecs[10] = '{3'd4, 32'h7FFFFFFF,  32'h80000000,  32'd0,         1'b0};
    vecs[11] = '{3'd5, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1};
    vecs[12] = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0};

    reset = 0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (2) @(posedge CLK);
    #1 mon_en = 1'b1;
    @(posedge CLK); #1 reset = 1;

    // ADD after reset, then MOD on requester 1
    do_op(0, 3'd5, 32'd5, 32'd7, 50, 1'b1, "t1_add", g, r0, l0, h0);
    chk("t1_add_value", r0, 32'd12);
    do_op(1, 3'd7, 32'd17, 32'd5, 50, 1'b1, "t2_mod", g, r1, l1, h1);
    chk("t2_mod_value", r1, 32'd2);

    // Tie straight after reset goes to requester 0
    do_reset();
    fork
      do_op(0, 3'd6, 32'd9, 32'd3, 100, 1'b1, "t3_sub", g, r0, l0, h0);
      do_op(1, 3'd4, 32'd3, 32'd9, 100, 1'b1, "t3_slt", g, r1, l1, h1);
    join
    chk("t3_order", h0 < h1, 1);
    chk("t3_sub_value", r0, 32'd6);
    chk("t3_slt_value", r1, 32'd1);
    chk("t3_slt_lt", l1, 1'b1);

    // Both requesters keep asking: grants alternate
    fork
      begin
        do_op(0, 3'd5, 32'd1, 32'd2, 100, 1'b1, "t4_a0", g, ra, la, h0);
        do_op(0, 3'd1, 32'd4, 32'd8, 100, 1'b1, "t4_b0", g, rb, lb, h0b);
      end
      begin
        do_op(1, 3'd0, 32'hFF, 32'h0F, 100, 1'b1, "t4_a1", g, ra, la, h1);
        do_op(1, 3'd6, 32'd10, 32'd4, 100, 1'b1, "t4_b1", g, rb, lb, h1b);
      end
    join
    chk("t4_alternate", (h0 < h1) && (h1 < h0b) && (h0b < h1b), 1);

    // Reset in the middle of a MOD
    @(posedge CLK); #1;
    req0_valid = 1; req0_op = 3'd7; req0_a = 32'd17; req0_b = 32'd5;
    @(negedge CLK);
    chk("t5_ready", req0_ready, 1);
    @(posedge CLK); #1 req0_valid = 0;
    repeat (10) @(posedge CLK);
    #3 reset = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_alu_op", alu_op, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_rsp0_result", rsp0_result, 0);
    chk("t5_rsp1_result", rsp1_result, 0);
    chk("t5_clear", alu_clear, 0);
    @(posedge CLK); @(posedge CLK); #1 reset = 1;
    seen = 0;
    repeat (45) begin
      @(negedge CLK);
      if (rsp0_valid || rsp1_valid) seen++;
    end
    chk("t5_no_rsp", seen, 0);
    fork
      do_op(0, 3'd5, 32'd2, 32'd3, 100, 1'b1, "t5_tie0", g, r0, l0, h0);
      do_op(1, 3'd5, 32'd4, 32'd5, 100, 1'b1, "t5_tie1", g, r1, l1, h1);
    join
    chk("t5_tie_order", h0 < h1, 1);

    // XOR then NOR, then operands stay at 0,0 while idle
    do_op(0, 3'd2, 32'hFFFF0000, 32'h0F0F0F0F, 50, 1'b1, "t6_xor", g, r0, l0, h0);
    chk("t6_xor_value", r0, 32'hF0F00F0F);
    do_op(1, 3'd3, 32'd0, 32'd0, 50, 1'b1, "t6_nor", g, r1, l1, h1);
    chk("t6_nor_value", r1, 32'hFFFFFFFF);
    repeat (3) begin
      @(negedge CLK);
      chk("t6_hold_a", alu_a, 32'd0);
      chk("t6_hold_b", alu_b, 32'd0);
    end

    // Table vectors, alternating requesters
    for (int i = 0; i < 13; i++) begin
      do_op(i % 2, vecs[i].op, vecs[i].a, vecs[i].b, 50, 1'b1, "tbl", g, r0, l0, h0);
      chk($sformatf("tbl%0d_res", i), r0, vecs[i].res);
      chk($sformatf("tbl%0d_lt", i), l0, vecs[i].lt);
    end

    // Random concurrent traffic, checked every cycle by the model
    fork
      rand_thread(0);
      rand_thread(1);
    join

    repeat (5) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit ALU (AND/OR/XOR/NOR/SLT/ADD/SUB/MOD) between two requesters.
- Accepts one operation at a time over a valid/ready handshake and latches the operands and opcode.
- Holds the ALU inputs stable for the op-dependent settling time, including the multi-cycle iterative MOD.
- Captures the ALU result and returns it to the originating requester as a one-cycle response pulse.
- Sits between the requesters (controller or test sequencer) and the ALU instance.

Parameters:
- ALU_LAT, 1, settle cycles for ops 000-110; legal range 1..255.
- MOD_LAT, 34, settle cycles for op 111 (MOD); legal range 1..255.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an op pending.
- req0_ready  out  1  requester 0 granted this cycle.
- req0_op  in  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD.
- req0_a  in  32  operand a.
- req0_b  in  32  operand b.
- rsp0_valid  out  1  one-cycle result pulse for requester 0.
- rsp0_result  out  32  result.
- rsp0_lt  out  1  captured less_than.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_result, rsp1_lt: same as requester 0, for requester 1.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_op  out  3  to ALU aluOP.
- alu_clear  out  1  one-cycle restart strobe to the ALU's iterative MOD unit.
- alu_o  in  32  ALU result O.
- alu_lt  in  1  ALU less_than.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: ready, rsp_valid, rsp results, rsp_lt, alu_a/b/op, alu_clear, busy.
  - Round-robin pointer set to last_grant=1, so requester 0 wins the first tie.
  - Any in-flight op is discarded and produces no response.
- FSM states:
  - IDLE:
    - reqN_ready is driven combinationally, only in IDLE.
    - If exactly one reqN_valid is high, that requester gets ready.
    - If both are high, the requester other than last_grant gets ready.
    - A handshake (valid & ready) latches op, a, b and the grant ID into alu_op/alu_a/alu_b, and updates last_grant.
    - A handshake moves the FSM to ISSUE. With no valid request, the FSM stays in IDLE.
  - ISSUE (1 cycle):
    - alu_clear=1.
    - Load the counter with MOD_LAT if op=111, otherwise ALU_LAT.
    - Next state is WAIT.
  - WAIT:
    - Counter decrements each cycle.
    - On the cycle where counter=1: capture alu_o and alu_lt into the granted requester's rsp_result/rsp_lt, then go to DONE.
  - DONE (1 cycle):
    - rspN_valid=1 for the granted requester only; the other rsp_valid stays 0.
    - Next state is IDLE.
- Latency and throughput:
  - Handshake at edge E0 gives rsp_valid high in cycle E0+LAT+2.
  - One op per LAT+3 cycles; no overlap or pipelining.
- Data hold rules:
  - alu_a/b/op stay constant from the handshake until the next handshake, including across IDLE.
  - rspN_result/rspN_lt hold their last value until the next capture for that requester.
  - Requesters must hold op/a/b stable only while valid is high without ready.
  - A requester may drop valid without penalty before it is granted.
- Simultaneous events:
  - A new valid arriving during ISSUE, WAIT or DONE is ignored until IDLE; ready stays 0.
  - When both requesters keep valid high, grants strictly alternate.
- Arithmetic: the block does no arithmetic on data; all 32 bits pass through unchanged.
- Illegal parameter values (LAT=0) are not supported.

Test Plan:
- Reset, then req0 ADD a=5 b=7 (ALU_LAT=1) -> req0_ready=1 in that cycle; alu_clear pulses at E0+1; rsp0_valid=1 at E0+3 with rsp0_result=12; rsp1_valid stays 0.
- req1 MOD a=17 b=5 (MOD_LAT=34) -> alu_op=111 held stable; rsp1_valid exactly at E0+36 with rsp1_result=2; busy=1 from E0+1 through E0+36.
- Both valid right after reset: req0 SUB 9-3, req1 SLT 3<9 -> req0 granted first, result 6; req1 granted at the next IDLE, rsp1_result=1 and rsp1_lt=1.
- Both requesters hold valid for 4 ops -> grants alternate 0,1,0,1; each response goes only to its issuer; ready never asserts outside IDLE.
- reset pulled low during WAIT of a MOD -> all outputs 0 immediately; no rsp_valid ever appears for that op; the next tie is granted to req0.
- XOR 0xFFFF0000 with 0x0F0F0F0F, then NOR 0 with 0 -> results 0xF0F00F0F then 0xFFFFFFFF; alu_a/b hold 0,0 through the following idle cycles.
